// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame geometry and baud divider derivation.
// TX and RX both take their timing from these functions so their bit periods agree.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  // Terminal count of a divider that ticks once per bit period.
  function automatic int bit_div(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate - 1;
  endfunction

  // Terminal count for the receiver's 16x oversampling tick.
  function automatic int ovs_tick_div(input int clk_freq, input int baud_rate);
    return clk_freq / (baud_rate * 16) - 1;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running divider: tick_o is high for one clock when the count reaches DIV, only while en_i.
// clr_i or a tick restarts the count at zero; with en_i low the count holds.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV = 433
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = cnt_width(DIV);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(DIV));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_rtl.sv
// UART transmitter: one byte per valid/ready handshake, start + 8 data LSB first + optional parity + 1/2 stop bits.
// txd falls on the handshake edge; tx_ready is low for the whole frame, so producers simply stall.
module uart_tx_rtl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       txd,
  output logic       busy
);

  localparam int BIT_DIV = bit_div(CLK_FREQ, BAUD_RATE);
  localparam int BCW     = $clog2(DATA_BITS);

  generate
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_rtl: STOP_BITS must be 1 or 2, got %0d", STOP_BITS);
    end
  endgenerate

  uart_state_e    state_q, state_d;
  logic [7:0]     shift_q, shift_d;
  logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
  logic           stop_cnt_q, stop_cnt_d;
  logic           parity_q, parity_d;
  logic           txd_q, txd_d;
  logic           handshake;
  logic           bit_tick;

  assign tx_ready  = (state_q == IDLE);
  assign busy      = ~tx_ready;
  assign handshake = tx_valid && tx_ready;
  assign txd       = txd_q;

  uart_baud_gen #(
    .DIV (BIT_DIV)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (busy),
    .clr_i  (handshake),
    .tick_o (bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    txd_d      = 1'b1;

    case (state_q)
      IDLE: begin
        if (handshake) begin
          shift_d    = tx_data;
          parity_d   = (^tx_data) ^ (PARITY_ODD != 0);
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_tick) begin
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            stop_cnt_d = 1'b0;
            state_d    = IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
      end
    endcase

    // txd is registered from the next state so the line changes on the same edge as the state.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = parity_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_rtl.sv
// Bench for uart_tx_rtl: three configurations driven from one clock, each frame compared against
// a bit-level waveform built from the byte and a mid-bit sampling receiver model.
module tb_uart_tx_rtl;

  logic       clk;
  logic       rst_n;
  logic [2:0] tx_valid;
  logic [7:0] tx_data [3];
  wire  [2:0] tx_ready;
  wire  [2:0] txd;
  wire  [2:0] busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_tx_rtl u_dut0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[0]), .tx_valid(tx_valid[0]),
    .tx_ready(tx_ready[0]), .txd(txd[0]), .busy(busy[0])
  );

  uart_tx_rtl #(
    .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[1]), .tx_valid(tx_valid[1]),
    .tx_ready(tx_ready[1]), .txd(txd[1]), .busy(busy[1])
  );

  uart_tx_rtl #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(62_500), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data[2]), .tx_valid(tx_valid[2]),
    .tx_ready(tx_ready[2]), .txd(txd[2]), .busy(busy[2])
  );

  // Reference line parameters of each instance.
  function automatic int nclk(input int k);
    case (k)
      2:       return 1_000_000 / 62_500;
      default: return 50_000_000 / 115200;
    endcase
  endfunction

  function automatic bit par_en(input int k);
    return (k != 0);
  endfunction

  function automatic bit par_odd(input int k);
    return (k == 2);
  endfunction

  function automatic int stops(input int k);
    return (k == 1) ? 2 : 1;
  endfunction

  function automatic int fbits(input int k);
    return 1 + 8 + int'(par_en(k)) + stops(k);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Caller has tx_valid/tx_data set up; the handshake happens on the next edge.
  task automatic run_frame(input int k, input logic [7:0] b, input bit hold, input bit poke,
                           output int hs);
    bit          lvl[$];
    logic [15:0] mid;
    logic [7:0]  rx;
    bit          flag;
    int          n;
    int          good;
    int          bad_ctl;
    int          idx;
    n       = nclk(k);
    bad_ctl = 0;
    mid     = '0;
    lvl.push_back(1'b0);
    for (int i = 0; i < 8; i++) lvl.push_back(b[i]);
    if (par_en(k)) lvl.push_back((^b) ^ par_odd(k));
    for (int i = 0; i < stops(k); i++) lvl.push_back(1'b1);

    check($sformatf("i%0d ready_before_hs", k), {31'd0, tx_ready[k]}, 32'd1);
    tick();
    hs = cyc;
    if (hold) tx_data[k] = 8'($urandom);
    else      tx_valid[k] = 1'b0;

    for (int i = 0; i < lvl.size(); i++) begin
      good = 0;
      for (int c = 0; c < n; c++) begin
        if (txd[k] === lvl[i]) good++;
        if (tx_ready[k] !== 1'b0 || busy[k] !== 1'b1) bad_ctl++;
        if (c == n / 2) mid[i] = txd[k];
        if (poke && i == 5 && c == 3) begin
          tx_valid[k] = 1'b1;
          tx_data[k]  = ~b;
        end
        if (poke && i == 5 && c == 9) tx_valid[k] = 1'b0;
        tick();
      end
      check($sformatf("i%0d byte%02h bit%0d clocks_at_level", k, b, i), good, n);
    end
    check($sformatf("i%0d byte%02h ctl_during_frame", k, b), bad_ctl, 0);
    check($sformatf("i%0d byte%02h ready_after", k, b), {31'd0, tx_ready[k]}, 32'd1);
    check($sformatf("i%0d byte%02h busy_after", k, b), {31'd0, busy[k]}, 32'd0);
    check($sformatf("i%0d byte%02h txd_gap", k, b), {31'd0, txd[k]}, 32'd1);

    // Receiver model: mid-bit samples, framing and parity flag.
    for (int j = 0; j < 8; j++) rx[j] = mid[1 + j];
    flag = (mid[0] != 1'b0);
    idx  = 9;
    if (par_en(k)) begin
      if (mid[9] != ((^rx) ^ par_odd(k))) flag = 1'b1;
      idx = 10;
    end
    for (int s = 0; s < stops(k); s++) if (mid[idx + s] != 1'b1) flag = 1'b1;
    check($sformatf("i%0d rx_byte", k), {24'd0, rx}, {24'd0, b});
    check($sformatf("i%0d rx_flag", k), {31'd0, flag}, 32'd0);
  endtask

  task automatic rand_frames(input int k, input int cnt);
    logic [7:0] b;
    bit         hold;
    int         hs;
    for (int i = 0; i < cnt; i++) begin
      b           = 8'($urandom);
      hold        = (i < cnt - 1) && ($urandom_range(0, 1) == 1);
      tx_valid[k] = 1'b1;
      tx_data[k]  = b;
      run_frame(k, b, hold, 1'b0, hs);
      if (!hold) repeat ($urandom_range(0, 3)) tick();
    end
    tx_valid[k] = 1'b0;
  endtask

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, hs1, hs2, bad, n0;
    n0       = nclk(0);
    rst_n    = 1'b0;
    tx_valid = '0;
    for (int k = 0; k < 3; k++) tx_data[k] = 8'h00;
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("i%0d reset_txd", k), {31'd0, txd[k]}, 32'd1);
      check($sformatf("i%0d reset_ready", k), {31'd0, tx_ready[k]}, 32'd1);
      check($sformatf("i%0d reset_busy", k), {31'd0, busy[k]}, 32'd0);
    end
    rst_n = 1'b1;

    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      if (txd !== 3'b111 || tx_ready !== 3'b111 || busy !== 3'b000) bad++;
      tick();
    end
    check("idle_1000_clocks", bad, 0);

    tx_valid[0] = 1'b1; tx_data[0] = 8'h55;
    run_frame(0, 8'h55, 1'b0, 1'b0, hs0);

    tx_valid[1] = 1'b1; tx_data[1] = 8'hA7;
    run_frame(1, 8'hA7, 1'b0, 1'b0, hs0);

    tx_valid[0] = 1'b1; tx_data[0] = 8'h00;
    run_frame(0, 8'h00, 1'b1, 1'b0, hs0);
    tx_data[0] = 8'hFF;
    run_frame(0, 8'hFF, 1'b1, 1'b0, hs1);
    tx_data[0] = 8'h3C;
    run_frame(0, 8'h3C, 1'b0, 1'b0, hs2);
    check("b2b_period_1", hs1 - hs0, fbits(0) * n0 + 1);
    check("b2b_period_2", hs2 - hs1, fbits(0) * n0 + 1);

    tx_valid[0] = 1'b1; tx_data[0] = 8'h96;
    run_frame(0, 8'h96, 1'b0, 1'b1, hs0);
    tick();

    // Abort in the middle of data bit 3.
    tx_valid[0] = 1'b1; tx_data[0] = 8'h0F;
    tick();
    tx_valid[0] = 1'b0;
    repeat (4 * n0 + n0 / 2) tick();
    check("abort_pre_txd_bit3", {31'd0, txd[0]}, 32'd1);
    check("abort_pre_busy", {31'd0, busy[0]}, 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_txd", {31'd0, txd[0]}, 32'd1);
    check("abort_busy", {31'd0, busy[0]}, 32'd0);
    check("abort_ready", {31'd0, tx_ready[0]}, 32'd1);
    bad = 0;
    for (int c = 0; c < 2 * n0; c++) begin
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
      tick();
    end
    check("abort_stays_idle", bad, 0);
    tx_valid[0] = 1'b1; tx_data[0] = 8'h81;
    run_frame(0, 8'h81, 1'b0, 1'b0, hs0);

    rand_frames(2, 30);
    rand_frames(1, 2);
    rand_frames(0, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
